// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 decoder family.
//   SEL_W / OUT_W : select and decoded-output widths
//   sel_t / out_t : typed select index and decoded word
//   onehot4()     : select index to one-hot word
package decoder_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OUT_W = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] out_t;

  // Bit `sel` set, all others clear.
  function automatic out_t onehot4(input sel_t sel);
    return OUT_W'(1) << sel;
  endfunction

endpackage : decoder_pkg

// File: rtl/decoder_2to4_core.sv
// Purely combinational enabled 2-to-4 decode.
//   a   : select MSB
//   b   : select LSB
//   e   : enable, active-high; low forces an all-zero word
//   y_c : one-hot decoded word (active-high polarity)
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             e,
  output logic [OUT_W-1:0] y_c
);

  // Disabled decode is all-zero so the output is never multi-hot.
  always_comb begin
    y_c = '0;
    if (e) begin
      y_c = onehot4({a, b});
    end
  end

endmodule : decoder_2to4_core

// File: rtl/decoder_2_to_4.sv
// Enabled 2-to-4 line decoder with optional output register and polarity.
//   REG_OUT    : 1 registers y (one-cycle latency), 0 drives y combinationally
//   ACTIVE_LOW : 1 inverts every bit of y (one-cold output, idle = all ones)
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high; loads the inactive value
//   a, b       : select MSB / LSB
//   e          : enable, active-high
//   y          : decoded output
module decoder_2_to_4
  import decoder_pkg::*;
#(
  parameter bit REG_OUT    = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             e,
  output logic [OUT_W-1:0] y
);

  // XOR mask applying the output polarity; also the inactive (idle) value.
  localparam logic [OUT_W-1:0] POL_MASK = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] dec_c;
  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;

  decoder_2to4_core u_core (
    .a   (a),
    .b   (b),
    .e   (e),
    .y_c (dec_c)
  );

  // Polarity applied before the register so the flop output is glitch-free.
  always_comb begin
    y_d = dec_c ^ POL_MASK;
  end

  // Output register; reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= POL_MASK;
    end else begin
      y_q <= y_d;
    end
  end

  // Combinational mode bypasses the register, so reset cannot reach y.
  assign y = REG_OUT ? y_q : y_d;

endmodule : decoder_2_to_4

// File: tb/tb_decoder_2_to_4.sv
// Scoreboard bench for decoder_2_to_4: registered active-high, registered
// active-low and combinational instances share one stimulus stream.
module tb_decoder_2_to_4;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       e;
  logic [3:0] y_hi;
  logic [3:0] y_lo;
  logic [3:0] y_cmb;

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] exp_hi_q[$];
  logic [3:0] exp_lo_q[$];

  decoder_2_to_4 #(.REG_OUT(1'b1), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .e(e), .y(y_hi)
  );

  decoder_2_to_4 #(.REG_OUT(1'b1), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .a(a), .b(b), .e(e), .y(y_lo)
  );

  decoder_2_to_4 #(.REG_OUT(1'b0), .ACTIVE_LOW(1'b0)) u_cmb (
    .clk(clk), .rst(rst), .a(a), .b(b), .e(e), .y(y_cmb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: selected line index is 2*a+b; value 2**index when enabled,
  // zero when disabled or held in reset; active-low is 15 minus that.
  function automatic logic [3:0] ref_y(input bit r, input bit ia, input bit ib,
                                       input bit ie, input bit al, input bit reg_out);
    int idx;
    int v;
    idx = 2 * int'(ia) + int'(ib);
    v   = 0;
    if (ie && !(r && reg_out)) v = 2 ** idx;
    if (al) v = 15 - v;
    return 4'(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, queue the registered
  // expectations, and check the combinational instance in the same step.
  task automatic apply(input bit r, input bit ia, input bit ib, input bit ie);
    @(negedge clk);
    rst = r;
    a   = ia;
    b   = ib;
    e   = ie;
    exp_hi_q.push_back(ref_y(r, ia, ib, ie, 1'b0, 1'b1));
    exp_lo_q.push_back(ref_y(r, ia, ib, ie, 1'b1, 1'b1));
    #1;
    check("comb", y_cmb, ref_y(r, ia, ib, ie, 1'b0, 1'b0));
  endtask

  // Monitor: the registered outputs present one result per rising edge.
  initial begin
    logic [3:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_hi_q.size() > 0) begin
        exp_v = exp_hi_q.pop_front();
        check("reg_hi", y_hi, exp_v);
      end
      if (exp_lo_q.size() > 0) begin
        exp_v = exp_lo_q.pop_front();
        check("reg_lo", y_lo, exp_v);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;
    e   = 1'b1;

    // Reset held two cycles with a live decode request, then released.
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 1'b1);

    // Full sweep with enable.
    for (int s = 0; s < 4; s++) apply(1'b0, s[1], s[0], 1'b1);

    // Disabled sweep, then re-enable on select 2.
    for (int s = 0; s < 4; s++) apply(1'b0, s[1], s[0], 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);

    // Mid-stream reset pulse.
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1);

    // Active-low spot checks (also exercised by the parallel instance).
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized stream with occasional reset.
    for (int i = 0; i < 200; i++) begin
      apply(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Drain: every queued expectation must have been consumed.
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_hi_q.size() != 0 || exp_lo_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0/0",
               exp_hi_q.size(), exp_lo_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_decoder_2_to_4
